recip_seq: RTL and testbench

RECIP_SEQ -- requirements
Module: recip_seq

---
 rtl/recip_seq.sv | 128 ++++++++++++
 tb/tb_recip_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/recip_seq.sv
// recip_seq: sequential X/Y ray reciprocal using one time-shared Q6.10 reciprocal unit.
// Produces signed 1/rx, 1/ry plus their magnitudes and saturation flags.

module recip_q610 (
    input  logic [15:0] i_x,
    input  logic        i_abs,
    output logic [15:0] o_data,
    output logic        o_sat
);
    logic [16:0] w_mag;
    logic [20:0] w_div;
    logic [20:0] w_quo;
    logic [14:0] w_res;
    assign w_mag  = i_x[15] ? (17'h10000 - {1'b0, i_x}) : {1'b0, i_x};
    assign w_div  = (w_mag == 17'd0) ? 21'd1 : {4'd0, w_mag};
    // 1.0 in Q6.10 squared is 2^20, so 2^20/|x| is |1/x| in Q6.10
    assign w_quo  = 21'h100000 / w_div;
    assign o_sat  = (w_mag == 17'd0) || (w_quo > 21'd32767);
    assign w_res  = o_sat ? 15'h7FFF : w_quo[14:0];
    assign o_data = (i_x[15] && !i_abs) ? (16'd0 - {1'b0, w_res}) : {1'b0, w_res};
endmodule

module recip_seq #(
    parameter bit ZERO_SAT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_rx,
    input  logic [15:0] in_ry,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_rcp_x,
    output logic [15:0] out_rcp_y,
    output logic [15:0] out_dlt_x,
    output logic [15:0] out_dlt_y,
    output logic        out_sat_x,
    output logic        out_sat_y,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, CALC_X, CALC_Y, DONE} state_t;
    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_rx;
    logic [15:0] r_ry;
    logic [15:0] r_rcp_x;
    logic [15:0] r_rcp_y;
    logic [15:0] r_dlt_x;
    logic [15:0] r_dlt_y;
    logic        r_sat_x;
    logic        r_sat_y;
    logic [15:0] w_op;
    logic [15:0] w_data;
    logic        w_sat;
    logic        w_zero;
    logic [15:0] w_rcp;
    logic        w_min;
    logic [15:0] w_dlt;
    logic        w_sat_all;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE)   ? (in_valid ? CALC_X : IDLE) :
                 (r_state == CALC_X) ? CALC_Y :
                 (r_state == CALC_Y) ? DONE :
                 (out_ready ? IDLE : DONE);
    end

    always_comb begin
        in_ready  = (r_state == IDLE) && !reset;
        out_valid = (r_state == DONE);
        busy      = (r_state != IDLE);
    end

    assign w_op = (r_state == CALC_X) ? r_rx : r_ry;

    recip_q610 u_rcp (
        .i_x    (w_op),
        .i_abs  (1'b0),
        .o_data (w_data),
        .o_sat  (w_sat)
    );

    assign w_zero    = ZERO_SAT && (w_op == 16'd0);
    assign w_rcp     = w_zero ? 16'h7FFF : w_data;
    // -0x8000 is not representable, so its magnitude clamps and is flagged
    assign w_min     = (w_rcp == 16'h8000);
    assign w_dlt     = w_min ? 16'h7FFF : (w_rcp[15] ? (16'd0 - w_rcp) : w_rcp);
    assign w_sat_all = w_zero || w_sat || w_min;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx    <= '0;
            r_ry    <= '0;
            r_rcp_x <= '0;
            r_rcp_y <= '0;
            r_dlt_x <= '0;
            r_dlt_y <= '0;
            r_sat_x <= 1'b0;
            r_sat_y <= 1'b0;
        end else if (r_state == IDLE && in_valid) begin
            r_rx <= in_rx;
            r_ry <= in_ry;
        end else if (r_state == CALC_X) begin
            r_rcp_x <= w_rcp;
            r_dlt_x <= w_dlt;
            r_sat_x <= w_sat_all;
        end else if (r_state == CALC_Y) begin
            r_rcp_y <= w_rcp;
            r_dlt_y <= w_dlt;
            r_sat_y <= w_sat_all;
        end
    end

    assign out_rcp_x = r_rcp_x;
    assign out_rcp_y = r_rcp_y;
    assign out_dlt_x = r_dlt_x;
    assign out_dlt_y = r_dlt_y;
    assign out_sat_x = r_sat_x;
    assign out_sat_y = r_sat_y;
endmodule

// File: tb/tb_recip_seq.sv
// tb_recip_seq: directed and random checks of recip_seq against a real-arithmetic reference.
module tb_recip_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] in_rx = '0;
    logic [15:0] in_ry = '0;
    logic        in_ready, out_valid, out_sat_x, out_sat_y, busy;
    logic [15:0] out_rcp_x, out_rcp_y, out_dlt_x, out_dlt_y;
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        logic [15:0] rcp;
        logic [15:0] dlt;
        logic        sat;
    } res_t;

    recip_seq #(.ZERO_SAT(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rx     (in_rx),
        .in_ry     (in_ry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rcp_x (out_rcp_x),
        .out_rcp_y (out_rcp_y),
        .out_dlt_x (out_dlt_x),
        .out_dlt_y (out_dlt_y),
        .out_sat_x (out_sat_x),
        .out_sat_y (out_sat_y),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic res_t model(input logic [15:0] x);
        res_t r;
        real  v;
        int   q;
        if (x == 16'd0) begin
            r = '{rcp: 16'h7FFF, dlt: 16'h7FFF, sat: 1'b1};
            return r;
        end
        v = 1048576.0 / $itor($signed(x));
        if (v > 32767.0) begin
            r = '{rcp: 16'h7FFF, dlt: 16'h7FFF, sat: 1'b1};
        end else if (v < -32767.0) begin
            r = '{rcp: 16'h8001, dlt: 16'h7FFF, sat: 1'b1};
        end else begin
            q = $rtoi(v);
            r.rcp = 16'(q);
            r.dlt = 16'(q < 0 ? -q : q);
            r.sat = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [15:0] rnd16();
        logic [15:0] v;
        v = 16'($urandom_range(0, 64));
        if ($urandom_range(0, 3) != 0) v = 16'($urandom);
        else if ($urandom_range(0, 1) == 1) v = 16'd0 - v;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        int d;
        d = int'($signed(obs)) - int'($signed(exp));
        tests++;
        assert (d >= -2 && d <= 2) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (+-2)", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic [15:0] x, input logic [15:0] rcp,
                           input logic [15:0] dlt, input logic sat);
        res_t m;
        m = model(x);
        if (m.sat) begin
            chk({tag, "_rcp"}, rcp, m.rcp);
            chk({tag, "_dlt"}, dlt, m.dlt);
        end else begin
            chk_tol({tag, "_rcp"}, rcp, m.rcp);
            chk_tol({tag, "_dlt"}, dlt, m.dlt);
        end
        chk({tag, "_sat"}, sat, m.sat);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_pair(input logic [15:0] rx, input logic [15:0] ry, input int hold);
        in_rx = rx;
        in_ry = ry;
        in_valid = 1'b1;
        chk("in_ready_idle", in_ready, 1);
        tick();
        in_valid = 1'($urandom_range(0, 1));
        in_rx = 16'($urandom);
        in_ry = 16'($urandom);
        chk("busy_calc", busy, 1);
        chk("in_ready_calc", in_ready, 0);
        chk("valid_calc_x", out_valid, 0);
        tick();
        chk_res("x_edge1", rx, out_rcp_x, out_dlt_x, out_sat_x);
        chk("valid_calc_y", out_valid, 0);
        tick();
        chk("valid_done", out_valid, 1);
        chk("in_ready_done", in_ready, 0);
        chk_res("x", rx, out_rcp_x, out_dlt_x, out_sat_x);
        chk_res("y", ry, out_rcp_y, out_dlt_y, out_sat_y);
        out_ready = (hold == 0);
        for (int i = 0; i < hold; i++) begin
            in_valid = ~in_valid;
            in_rx = 16'($urandom);
            tick();
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk_res("hold_x", rx, out_rcp_x, out_dlt_x, out_sat_x);
            chk_res("hold_y", ry, out_rcp_y, out_dlt_y, out_sat_y);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("release_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] p;
        int          nv;
        int          last;
        int          acc;
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rcp_x", out_rcp_x, 0);
        chk("rst_dlt_y", out_dlt_y, 0);
        chk("rst_sat", {out_sat_x, out_sat_y}, 0);
        tick();
        reset = 1'b0;
        tick();

        run_pair(16'h0800, 16'hFE00, 0);
        run_pair(16'h0000, 16'h0001, 0);
        run_pair(16'hFFFF, 16'h8000, 0);
        run_pair(16'h0020, 16'h0021, 0);
        run_pair(16'hFFE0, 16'h7FFF, 0);
        run_pair(16'h0800, 16'hFE00, 5);
        for (int i = 0; i < 10; i++) run_pair(rnd16(), rnd16(), 0);

        // directed exact values for the reference cases
        run_pair(16'h0800, 16'hFE00, 0);
        chk("d019_rcp_x", out_rcp_x, 16'h0200);
        chk("d019_rcp_y", out_rcp_y, 16'hF800);
        chk("d019_dlt_y", out_dlt_y, 16'h0800);
        run_pair(16'hFFFF, 16'h0400, 0);
        chk("d021_rcp_x", out_rcp_x, 16'h8001);
        chk("d021_dlt_x", out_dlt_x, 16'h7FFF);
        chk("d021_sat_x", out_sat_x, 1);

        // reset during CALC_Y
        in_rx = 16'h0400;
        in_ry = 16'h0400;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_rcp_x", out_rcp_x, 0);
        chk("mid_rst_dlt_x", out_dlt_x, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        tick();
        tick();
        #3 reset = 1'b0;
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            nv += int'(out_valid);
        end
        chk("no_stale_valid", nv, 0);
        run_pair(16'h0C00, 16'hF400, 0);

        // back-to-back with out_ready high
        out_ready = 1'b1;
        last = -1;
        acc = 0;
        for (int c = 0; c < 52; c++) begin
            in_valid = (c < 44);
            if (out_valid) begin
                chk("b2b_queue_nonempty", q.size() != 0, 1);
                if (q.size() != 0) begin
                    p = q.pop_front();
                    chk_res("b2b_x", p[31:16], out_rcp_x, out_dlt_x, out_sat_x);
                    chk_res("b2b_y", p[15:0], out_rcp_y, out_dlt_y, out_sat_y);
                end
            end
            if (in_ready && in_valid) begin
                in_rx = rnd16();
                in_ry = rnd16();
                q.push_back({in_rx, in_ry});
                if (last >= 0) chk("b2b_gap", c - last, 4);
                last = c;
                acc++;
            end
            tick();
        end
        chk("b2b_accepts", acc, 11);
        chk("b2b_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
